// File: rtl/cortex_m0_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first by default.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT data grants in a row.
`timescale 1ns/1ps
module cortex_m0_bus_arbiter #(
    parameter int BW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [BW-1:0] if_addr,
    output logic          if_ack,
    output logic [BW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [1:0]    ls_size,
    input  logic [BW-1:0] ls_addr,
    input  logic [BW-1:0] ls_wdata,
    output logic          ls_ack,
    output logic [BW-1:0] ls_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [1:0]    mem_size,
    output logic [BW-1:0] mem_addr,
    output logic [BW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [BW-1:0] mem_rdata,
    output logic [1:0]    dbg_state_o,
    output logic [3:0]    dbg_starve_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   arb_en;
    logic   fetch_first;

    // A grant is only re-decided from IDLE or in the cycle the current transfer completes.
    assign arb_en = (state_q == IDLE) || mem_ack;

    always_comb begin
        state_d = state_q;
        if (arb_en) begin
            if (ls_req && if_req && fetch_first) begin
                state_d = FETCH;
            end else if (ls_req) begin
                state_d = DATA;
            end else if (if_req) begin
                state_d = FETCH;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign fetch_first = (starve_cnt_q == LIMIT);

    // Counts data grants that fetch had to watch; any fetch grant clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (arb_en) begin
            if (state_d == FETCH) begin
                starve_cnt_d = 4'd0;
            end else if (state_d == DATA && if_req && starve_cnt_q != LIMIT) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign dbg_starve_cnt_o = starve_cnt_q;
`else
    assign fetch_first      = 1'b0;
    assign dbg_starve_cnt_o = 4'd0;
`endif

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ack    = 1'b0;
        ls_ack    = 1'b0;
        unique case (state_q)
            FETCH: begin
                mem_req  = 1'b1;
                mem_size = 2'd2;
                mem_addr = if_addr;
                if_ack   = mem_ack;
            end
            DATA: begin
                mem_req   = 1'b1;
                mem_we    = ls_we;
                mem_size  = ls_size;
                mem_addr  = ls_addr;
                mem_wdata = ls_wdata;
                ls_ack    = mem_ack;
            end
            default: ;
        endcase
    end

    assign if_rdata    = mem_rdata;
    assign ls_rdata    = mem_rdata;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cortex_m0_bus_arbiter.sv
// Bench for cortex_m0_bus_arbiter: directed scenarios plus randomized requesters and memory,
// checked against a transaction-level owner model and per-requester expected queues.
`timescale 1ns/1ps
module tb_cortex_m0_bus_arbiter;
    localparam int BW    = 32;
    localparam int LIMIT = 4;

    typedef struct {
        logic [BW-1:0] addr;
        logic          we;
        logic [1:0]    size;
        logic [BW-1:0] wdata;
        logic [BW-1:0] rdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, ls_req, ls_we, mem_ack;
    logic [BW-1:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [1:0]    ls_size;
    logic          if_ack, ls_ack, mem_req, mem_we;
    logic [BW-1:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [1:0]    mem_size, dbg_state_o;
    logic [3:0]    dbg_starve_cnt_o;

    txn_t if_exp_q[$];
    txn_t ls_exp_q[$];
    int   checks = 0;
    int   errors = 0;
    // Requester modes: 0 idle, 1 random, 2 re-issue on every ack, 3 drop on ack.
    int   if_mode = 0;
    int   ls_mode = 0;
    // Memory modes: 0 driven by the main sequence, 1 random, 2 ack every cycle.
    int   resp_mode = 0;
    // Owner the model expects for the current cycle: 0 none, 1 fetch, 2 data.
    int   exp_owner = 0;
    int   exp_cnt = 0;
    int   model_next;

    cortex_m0_bus_arbiter #(.BW(BW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dbg_state_o(dbg_state_o), .dbg_starve_cnt_o(dbg_starve_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] rdata_of(input logic [BW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue_if(input logic [BW-1:0] a, input logic [BW-1:0] rd);
        txn_t t;
        t.addr = a; t.we = 1'b0; t.size = 2'd2; t.wdata = '0; t.rdata = rd;
        if_exp_q.push_back(t);
        if_req  = 1'b1;
        if_addr = a;
    endtask

    task automatic issue_ls(input logic we, input logic [1:0] sz, input logic [BW-1:0] a,
                            input logic [BW-1:0] wd, input logic [BW-1:0] rd);
        txn_t t;
        t.addr = a; t.we = we; t.size = sz; t.wdata = wd; t.rdata = rd;
        ls_exp_q.push_back(t);
        ls_req   = 1'b1;
        ls_we    = we;
        ls_size  = sz;
        ls_addr  = a;
        ls_wdata = wd;
    endtask

    task automatic issue_if_rand();
        logic [BW-1:0] a;
        a = $urandom & 32'hFFFF_FFFC;
        issue_if(a, rdata_of(a));
    endtask

    task automatic issue_ls_rand();
        logic [BW-1:0] a;
        a = $urandom;
        issue_ls(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), a, $urandom, rdata_of(a));
    endtask

    // Fetch requester: reacts to its ack in the same cycle, after the monitor has sampled.
    always @(negedge clk) begin
        #1;
        if (reset && if_req && if_ack) begin
            case (if_mode)
                1: if ($urandom_range(0, 1) == 1) issue_if_rand(); else if_req = 1'b0;
                2: issue_if(if_addr, rdata_of(if_addr));
                3: if_req = 1'b0;
                default: ;
            endcase
        end else if (if_mode == 1 && !if_req && $urandom_range(0, 3) == 0) begin
            issue_if_rand();
        end
    end

    always @(negedge clk) begin
        #1;
        if (reset && ls_req && ls_ack) begin
            case (ls_mode)
                1: if ($urandom_range(0, 2) != 0) issue_ls_rand(); else ls_req = 1'b0;
                2: issue_ls(ls_we, ls_size, ls_addr, ls_wdata, rdata_of(ls_addr));
                3: ls_req = 1'b0;
                default: ;
            endcase
        end else if (ls_mode == 1 && !ls_req && $urandom_range(0, 2) == 0) begin
            issue_ls_rand();
        end
    end

    // Memory: random completion latency, occasional stray acks while nothing is requested.
    always @(posedge clk) begin
        #1;
        if (resp_mode == 1) begin
            mem_ack = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        end else if (resp_mode == 2) begin
            mem_ack = 1'b1;
        end
        if (resp_mode != 0) begin
            mem_rdata = mem_ack ? rdata_of(mem_addr) : $urandom;
        end
    end

    // Reference model: the bus belongs to one requester until memory completes it; then data
    // wins unless fetch has already sat through LIMIT data grants.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            exp_owner = 0;
            exp_cnt   = 0;
        end else if (exp_owner == 0 || mem_ack) begin
            model_next = ls_req ? 2 : (if_req ? 1 : 0);
`ifdef ARB_STARVE_GUARD_EN
            if (ls_req && if_req && exp_cnt >= LIMIT) model_next = 1;
            if (model_next == 1) exp_cnt = 0;
            else if (model_next == 2 && if_req) exp_cnt = (exp_cnt < LIMIT) ? exp_cnt + 1 : LIMIT;
`endif
            exp_owner = model_next;
        end
    end

    always @(negedge reset) begin
        exp_owner = 0;
        exp_cnt   = 0;
    end

    // Monitor: compares acks and bus contents with the model and pops expected transfers.
    always @(negedge clk) begin
        if (reset) begin
            txn_t t;
            check("if_ack", if_ack, (exp_owner == 1) && mem_ack);
            check("ls_ack", ls_ack, (exp_owner == 2) && mem_ack);
            check("mem_req", mem_req, exp_owner != 0);
            check("starve_cnt", dbg_starve_cnt_o, exp_cnt);
            if (exp_owner == 0) begin
                check("idle_addr", mem_addr, 0);
                check("idle_wdata", mem_wdata, 0);
                check("idle_we", mem_we, 0);
                check("idle_size", mem_size, 0);
            end else if ((exp_owner == 1 && if_exp_q.size() == 0) ||
                         (exp_owner == 2 && ls_exp_q.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL owner_queue: got empty queue required a pending transfer at %0t", $time);
            end else begin
                t = (exp_owner == 1) ? if_exp_q[0] : ls_exp_q[0];
                check("bus_addr", mem_addr, t.addr);
                check("bus_we", mem_we, t.we);
                check("bus_size", mem_size, t.size);
                if (t.we) check("bus_wdata", mem_wdata, t.wdata);
                if (mem_ack) begin
                    if (!t.we) check("rdata", (exp_owner == 1) ? if_rdata : ls_rdata, t.rdata);
                    if (exp_owner == 1) void'(if_exp_q.pop_front());
                    else void'(ls_exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int            ls_before, if_seen, first_if;
        logic [1:0]    idle_code;
        reset = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_ls_ack", ls_ack, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_cnt", dbg_starve_cnt_o, 0);
        idle_code = dbg_state_o;
        @(posedge clk); #2 reset = 1'b1;

        // Single fetch, completed two cycles after the request reaches memory.
        @(negedge clk); #1;
        if_mode = 3;
        issue_if(32'h100, 32'hBF00_BF00);
        @(posedge clk); #1;
        check("fetch_mem_req", mem_req, 1);
        check("fetch_addr", mem_addr, 32'h100);
        check("fetch_we", mem_we, 0);
        check("fetch_size", mem_size, 2);
        @(posedge clk); #1;
        check("fetch_wait_ack", if_ack, 0);
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hBF00_BF00; #1;
        check("fetch_if_ack", if_ack, 1);
        check("fetch_if_rdata", if_rdata, 32'hBF00_BF00);
        @(posedge clk); #1;
        mem_ack = 1'b0; #1;
        check("fetch_ack_pulse", if_ack, 0);
        check("fetch_back_idle", mem_req, 0);

        // Both request together: store first, then fetch with no idle cycle between.
        @(negedge clk); #1;
        ls_mode = 3;
        issue_ls(1'b1, 2'd2, 32'h2000_0004, 32'h1234, '0);
        issue_if(32'h200, 32'hCAFE_0200);
        @(posedge clk); #1;
        check("both_data_first_we", mem_we, 1);
        check("both_data_first_addr", mem_addr, 32'h2000_0004);
        check("both_data_wdata", mem_wdata, 32'h1234);
        mem_ack = 1'b1; #1;
        check("both_ls_ack", ls_ack, 1);
        check("both_if_ack_held", if_ack, 0);
        @(posedge clk); #1;
        mem_ack = 1'b0; #1;
        check("both_fetch_next_req", mem_req, 1);
        check("both_fetch_next_addr", mem_addr, 32'h200);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0200; #1;
        check("both_fetch_ack", if_ack, 1);
        @(posedge clk); #1;
        mem_ack = 1'b0;

        // Stray completion while idle.
        @(posedge clk); #1;
        mem_ack = 1'b1; #1;
        check("stray_if_ack", if_ack, 0);
        check("stray_ls_ack", ls_ack, 0);
        @(posedge clk); #1;
        check("stray_stays_idle", mem_req, 0);
        check("stray_state", dbg_state_o, idle_code);
        mem_ack = 1'b0;

        // Reset in the middle of a data transfer, then a re-grant from idle.
        @(negedge clk); #1;
        issue_ls(1'b0, 2'd1, 32'h2000_0040, '0, rdata_of(32'h2000_0040));
        @(posedge clk); #1;
        check("pre_rst_grant", mem_req, 1);
        @(posedge clk); #3;
        reset = 1'b0; #1;
        check("rst_async_mem_req", mem_req, 0);
        check("rst_no_ls_ack", ls_ack, 0);
        check("rst_async_addr", mem_addr, 0);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        check("regrant_req", mem_req, 1);
        check("regrant_addr", mem_addr, 32'h2000_0040);
        mem_ack = 1'b1; mem_rdata = rdata_of(32'h2000_0040); #1;
        check("regrant_ls_ack", ls_ack, 1);
        @(posedge clk); #1;
        mem_ack = 1'b0;

        // Both requesters stream while memory completes every cycle.
        @(negedge clk); #1;
        if_mode = 2; ls_mode = 2;
        issue_ls(1'b0, 2'd2, 32'h2000_0100, '0, rdata_of(32'h2000_0100));
        issue_if(32'h400, rdata_of(32'h400));
        resp_mode = 2;
        ls_before = 0; if_seen = 0; first_if = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (first_if >= 0 && i == first_if + 1) check("starve_cnt_cleared", dbg_starve_cnt_o, 0);
            if (if_ack) begin
                if_seen++;
                if (first_if < 0) first_if = i;
            end
            if (ls_ack && first_if < 0) ls_before++;
        end
`ifdef ARB_STARVE_GUARD_EN
        check("starve_ls_before_if", ls_before, LIMIT);
        check("starve_if_granted", first_if >= 0, 1);
`else
        check("fixed_no_if_ack", if_seen, 0);
        check("fixed_all_ls", ls_before, 12);
`endif

        // Randomized traffic.
        @(negedge clk); #1;
        if_mode = 1; ls_mode = 1; resp_mode = 1;
        repeat (3000) @(posedge clk);
        @(negedge clk); #1;
        if_mode = 3; ls_mode = 3;
        for (int i = 0; i < 400 && (if_req || ls_req); i++) @(posedge clk);
        check("drain_if_req", if_req, 0);
        check("drain_ls_req", ls_req, 0);
        @(posedge clk); #2;
        resp_mode = 0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        check("if_queue_drained", if_exp_q.size(), 0);
        check("ls_queue_drained", ls_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
